sbox_arbiter: RTL and testbench
===============================

SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the maximum number of outstanding S-Box lookups.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports dp_req (in, 1) and dp_addr (in, 32): round-datapath lookup request; byte0 is in [7:0].
REQ-005 The block SHALL have ports dp_gnt (out, 1), dp_rsp_vld (out, 1) and dp_rsp (out, 32): round-datapath grant, response strobe and substituted word.
REQ-006 The block SHALL have ports ks_req (in, 1) and ks_addr (in, 32): key-schedule SubWord lookup request.
REQ-007 The block SHALL have ports ks_gnt (out, 1), ks_rsp_vld (out, 1) and ks_rsp (out, 32): key-schedule grant, response strobe and substituted word.
REQ-008 The block SHALL have ports sb_en (out, 1) and sb_addr (out, 32): shared S-Box read enable and four byte addresses.
REQ-009 The block SHALL have ports sb_flag (in, 1) and sb_data (in, 32): S-Box result strobe and four substituted bytes.
REQ-010 The block SHALL have ports busy (out, 1): lookups in flight; and err (out, 1): sticky protocol error.

Function
REQ-011 Requester handshake: a requester SHALL hold req high and addr stable until it sees gnt high at a rising edge; gnt is combinational and lasts one cycle per accepted word.
REQ-012 A grant SHALL be issued only when the owner FIFO count is below FIFO_DEPTH, evaluated before any same-cycle pop; full blocks grants even if a pop occurs that cycle.
REQ-013 If only one requester is asserting and the FIFO is not full, that requester SHALL be granted.
REQ-014 On simultaneous requests, the requester not granted most recently SHALL win (round-robin). After reset the pointer SHALL favour ks.
REQ-015 At most one of dp_gnt and ks_gnt SHALL be high in any cycle; grants MAY issue on consecutive cycles.
REQ-016 On an edge with a grant, sb_en SHALL register 1, sb_addr SHALL register the granted addr, and the owner (dp=0, ks=1) SHALL be pushed into the FIFO.
REQ-017 On an edge without a grant, sb_en SHALL register 0 and sb_addr SHALL hold its value.
REQ-018 Responses are assumed in issue order. On an edge with sb_flag=1 and the FIFO non-empty, the head owner's rsp_vld SHALL register 1 and its rsp SHALL register sb_data; the head is then popped.
REQ-019 The other requester's rsp_vld SHALL register 0 on that edge, and its rsp SHALL hold.
REQ-020 rsp_vld SHALL be a one-cycle pulse; rsp SHALL hold its last value between responses.
REQ-021 If sb_flag=1 while the FIFO is empty, the block SHALL set err to 1 (sticky until reset), discard sb_data, and pulse no rsp_vld.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 busy SHALL equal (FIFO count != 0) OR sb_en.
REQ-025 End-to-end latency SHALL be 2 cycles plus the S-Box latency from the grant edge to rsp_vld; the block imposes no fixed S-Box latency.

Reset
REQ-026 While rst=0, the block SHALL asynchronously force to 0: dp_gnt, ks_gnt, sb_en, sb_addr, dp_rsp_vld, dp_rsp, ks_rsp_vld, ks_rsp, err and busy.
REQ-027 While rst=0, the FIFO SHALL be emptied and the round-robin pointer set to favour ks.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight ownership; sb_flag arriving after reset release with an empty FIFO SHALL set err.
REQ-029 Grants SHALL NOT issue while rst=0.

Verification
REQ-030 Single dp: dp_req=1, dp_addr=0x00010203 -> dp_gnt same cycle; next edge sb_en=1, sb_addr=0x00010203; sb_flag=1, sb_data=0x637C777B -> next edge dp_rsp_vld=1, dp_rsp=0x637C777B, ks_rsp_vld=0.
REQ-031 Contention: both req from reset -> ks granted first, then dp. Responses 0xAAAAAAAA then 0xBBBBBBBB -> ks_rsp=0xAAAAAAAA, then dp_rsp=0xBBBBBBBB.
REQ-032 Full: dp_req held with no sb_flag -> exactly 4 grants then dp_gnt=0; one sb_flag pulse -> exactly one further grant, on a later cycle.
REQ-033 Spurious: sb_flag=1 with the FIFO empty -> err=1, no rsp_vld; err stays 1 until rst=0.
REQ-034 Reset mid-flight: 2 lookups issued, rst=0 for 1 cycle -> all outputs 0 and busy=0; a later sb_flag -> err=1.
REQ-035 Back-to-back: alternate dp/ks requests for 8 cycles with 1-cycle S-Box echo -> each response routed to its issuing requester, in order, and sb_en high every cycle after the first.

Source files
------------

// File: rtl/sbox_arbiter_if.sv
`default_nettype none
// ============================================================================
// sbox_arbiter_if : requester, S-Box and status signals of the S-Box arbiter
// Revision 1.0
// ============================================================================
interface sbox_arbiter_if;
  logic        dp_req;
  logic [31:0] dp_addr;
  logic        dp_gnt;
  logic        dp_rsp_vld;
  logic [31:0] dp_rsp;
  logic        ks_req;
  logic [31:0] ks_addr;
  logic        ks_gnt;
  logic        ks_rsp_vld;
  logic [31:0] ks_rsp;
  logic        sb_en;
  logic [31:0] sb_addr;
  logic        sb_flag;
  logic [31:0] sb_data;
  logic        busy;
  logic        err;

  modport slave (
    input  dp_req, dp_addr, ks_req, ks_addr, sb_flag, sb_data,
    output dp_gnt, dp_rsp_vld, dp_rsp, ks_gnt, ks_rsp_vld, ks_rsp,
           sb_en, sb_addr, busy, err
  );

  modport master (
    output dp_req, dp_addr, ks_req, ks_addr, sb_flag, sb_data,
    input  dp_gnt, dp_rsp_vld, dp_rsp, ks_gnt, ks_rsp_vld, ks_rsp,
           sb_en, sb_addr, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/sbox_arbiter.sv
`default_nettype none
// ============================================================================
// sbox_arbiter : round-robin sharing of one S-Box between datapath and key schedule
// Revision 1.0
// ============================================================================
module sbox_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  sbox_arbiter_if.slave   bus
);

  localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Owner FIFO: one bit per outstanding lookup, 0 = dp, 1 = ks
  logic [FIFO_DEPTH-1:0] owner_q;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  rr_ks;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_ks;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = bus.dp_gnt | bus.ks_gnt;
  assign pop     = bus.sb_flag & ~empty;
  assign head_ks = owner_q[rd_ptr];
  assign bus.busy = (count != '0) | bus.sb_en;

  // Fullness uses the pre-pop count, so a pop never frees a slot in its own cycle
  always_comb begin
    bus.dp_gnt = 1'b0;
    bus.ks_gnt = 1'b0;
    if (rst && !full) begin
      if (bus.dp_req && (!bus.ks_req || !rr_ks))
        bus.dp_gnt = 1'b1;
      else if (bus.ks_req)
        bus.ks_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rr_ks          <= 1'b1;
      bus.sb_en      <= 1'b0;
      bus.sb_addr    <= '0;
      bus.dp_rsp_vld <= 1'b0;
      bus.dp_rsp     <= '0;
      bus.ks_rsp_vld <= 1'b0;
      bus.ks_rsp     <= '0;
      bus.err        <= 1'b0;
    end else begin
      bus.sb_en <= push;
      if (push) begin
        bus.sb_addr     <= bus.dp_gnt ? bus.dp_addr : bus.ks_addr;
        owner_q[wr_ptr] <= bus.ks_gnt;
        wr_ptr          <= next_ptr(wr_ptr);
      end

      if (bus.dp_gnt)
        rr_ks <= 1'b1;
      else if (bus.ks_gnt)
        rr_ks <= 1'b0;

      if (pop)
        rd_ptr <= next_ptr(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      bus.dp_rsp_vld <= pop & ~head_ks;
      bus.ks_rsp_vld <= pop &  head_ks;
      if (pop && !head_ks)
        bus.dp_rsp <= bus.sb_data;
      if (pop && head_ks)
        bus.ks_rsp <= bus.sb_data;

      if (bus.sb_flag && empty)
        bus.err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sbox_arbiter : directed vector table plus hand sequences for sbox_arbiter
// Revision 1.0
// ============================================================================
module tb_sbox_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sbox_arbiter_if bus ();

  sbox_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        dp_req;
    logic [31:0] dp_addr;
    logic        ks_req;
    logic [31:0] ks_addr;
    logic        sb_flag;
    logic [31:0] sb_data;
    logic        dp_gnt;
    logic        ks_gnt;
    logic        sb_en;
    logic [31:0] sb_addr;
    logic        dp_vld;
    logic [31:0] dp_rsp;
    logic        ks_vld;
    logic [31:0] ks_rsp;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    //        dp_req dp_addr       ks_req ks_addr       flg data          dgnt kgnt en  sb_addr       dvld dp_rsp        kvld ks_rsp        busy err
    vecs[0]  = '{1'b1, 32'h00010203, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00010203, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00010203, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h637C777B, 1'b0, 1'b0, 1'b0, 32'h00010203, 1'b1, 32'h637C777B, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00010203, 1'b0, 32'h637C777B, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h22222222, 1'b0, 32'h637C777B, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h11111111, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h637C777B, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h637C777B, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBBBBBBBB, 1'b0, 1'b0, 1'b0, 32'h11111111, 1'b1, 32'hBBBBBBBB, 1'b0, 32'hAAAAAAAA, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h0A0B0C0D, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0A0B0C0D, 1'b0, 32'hBBBBBBBB, 1'b0, 32'hAAAAAAAA, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 32'h1A1B1C1D, 1'b1, 32'hD0000001, 1'b0, 1'b1, 1'b1, 32'h1A1B1C1D, 1'b1, 32'hD0000001, 1'b0, 32'hAAAAAAAA, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h2A2B2C2D, 1'b0, 32'h0,        1'b1, 32'hD0000002, 1'b1, 1'b0, 1'b1, 32'h2A2B2C2D, 1'b0, 32'hD0000001, 1'b1, 32'hD0000002, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 32'h3A3B3C3D, 1'b1, 32'hD0000003, 1'b0, 1'b1, 1'b1, 32'h3A3B3C3D, 1'b1, 32'hD0000003, 1'b0, 32'hD0000002, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hD0000004, 1'b0, 1'b0, 1'b0, 32'h3A3B3C3D, 1'b0, 32'hD0000003, 1'b1, 32'hD0000004, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hEEEEEEEE, 1'b0, 1'b0, 1'b0, 32'h3A3B3C3D, 1'b0, 32'hD0000003, 1'b0, 32'hD0000004, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h3A3B3C3D, 1'b0, 32'hD0000003, 1'b0, 32'hD0000004, 1'b0, 1'b1};

    // Reset state, with both requesters asserting to show grants are blocked
    bus.dp_req  = 1'b1;
    bus.dp_addr = 32'hDEADBEEF;
    bus.ks_req  = 1'b1;
    bus.ks_addr = 32'hCAFEF00D;
    bus.sb_flag = 1'b0;
    bus.sb_data = 32'h0;
    repeat (2) tick();
    chk("rst_dp_gnt", 32'(bus.dp_gnt), 32'h0);
    chk("rst_ks_gnt", 32'(bus.ks_gnt), 32'h0);
    chk("rst_sb_en", 32'(bus.sb_en), 32'h0);
    chk("rst_sb_addr", bus.sb_addr, 32'h0);
    chk("rst_dp_vld", 32'(bus.dp_rsp_vld), 32'h0);
    chk("rst_dp_rsp", bus.dp_rsp, 32'h0);
    chk("rst_ks_vld", 32'(bus.ks_rsp_vld), 32'h0);
    chk("rst_ks_rsp", bus.ks_rsp, 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus.dp_req  = vecs[i].dp_req;
      bus.dp_addr = vecs[i].dp_addr;
      bus.ks_req  = vecs[i].ks_req;
      bus.ks_addr = vecs[i].ks_addr;
      bus.sb_flag = vecs[i].sb_flag;
      bus.sb_data = vecs[i].sb_data;
      #2;
      chk($sformatf("v%0d_dp_gnt", i), 32'(bus.dp_gnt), 32'(vecs[i].dp_gnt));
      chk($sformatf("v%0d_ks_gnt", i), 32'(bus.ks_gnt), 32'(vecs[i].ks_gnt));
      tick();
      chk($sformatf("v%0d_sb_en", i), 32'(bus.sb_en), 32'(vecs[i].sb_en));
      chk($sformatf("v%0d_sb_addr", i), bus.sb_addr, vecs[i].sb_addr);
      chk($sformatf("v%0d_dp_vld", i), 32'(bus.dp_rsp_vld), 32'(vecs[i].dp_vld));
      chk($sformatf("v%0d_dp_rsp", i), bus.dp_rsp, vecs[i].dp_rsp);
      chk($sformatf("v%0d_ks_vld", i), 32'(bus.ks_rsp_vld), 32'(vecs[i].ks_vld));
      chk($sformatf("v%0d_ks_rsp", i), bus.ks_rsp, vecs[i].ks_rsp);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].err));
    end

    // FIFO full: four grants, then a pop cycle that must not grant, then one refill
    bus.dp_req  = 1'b1;
    bus.dp_addr = 32'hF0F0F0F0;
    bus.ks_req  = 1'b0;
    bus.sb_flag = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (bus.dp_gnt) n++;
      tick();
    end
    chk("full_grant_count", 32'(n), 32'd4);
    #2;
    chk("full_gnt_low", 32'(bus.dp_gnt), 32'h0);
    chk("full_busy", 32'(bus.busy), 32'h1);
    bus.sb_flag = 1'b1;
    bus.sb_data = 32'h5A5A5A5A;
    chk("full_pop_cycle_gnt", 32'(bus.dp_gnt), 32'h0);
    tick();
    bus.sb_flag = 1'b0;
    chk("full_pop_dp_vld", 32'(bus.dp_rsp_vld), 32'h1);
    chk("full_pop_dp_rsp", bus.dp_rsp, 32'h5A5A5A5A);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (bus.dp_gnt) n++;
      tick();
    end
    chk("full_refill_count", 32'(n), 32'd1);
    bus.dp_req = 1'b0;

    // Clean reset clears sticky err
    rst = 1'b0;
    #2;
    chk("rst2_err", 32'(bus.err), 32'h0);
    chk("rst2_busy", 32'(bus.busy), 32'h0);
    tick();
    rst = 1'b1;

    // Two lookups in flight, then reset mid-flight
    bus.dp_req  = 1'b1;
    bus.dp_addr = 32'h01020304;
    tick();
    bus.dp_req  = 1'b0;
    bus.ks_req  = 1'b1;
    bus.ks_addr = 32'h05060708;
    tick();
    bus.ks_req  = 1'b0;
    chk("mid_sb_addr", bus.sb_addr, 32'h05060708);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    bus.dp_req = 1'b1;
    rst = 1'b0;
    #2;
    chk("mid_rst_dp_gnt", 32'(bus.dp_gnt), 32'h0);
    chk("mid_rst_sb_en", 32'(bus.sb_en), 32'h0);
    chk("mid_rst_sb_addr", bus.sb_addr, 32'h0);
    chk("mid_rst_dp_rsp", bus.dp_rsp, 32'h0);
    chk("mid_rst_ks_rsp", bus.ks_rsp, 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    tick();
    rst = 1'b1;
    bus.dp_req = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    bus.sb_flag = 1'b1;
    bus.sb_data = 32'h99999999;
    tick();
    bus.sb_flag = 1'b0;
    chk("post_rst_err", 32'(bus.err), 32'h1);
    chk("post_rst_dp_vld", 32'(bus.dp_rsp_vld), 32'h0);
    chk("post_rst_ks_vld", 32'(bus.ks_rsp_vld), 32'h0);
    chk("post_rst_dp_rsp", bus.dp_rsp, 32'h0);
    tick();
    chk("post_rst_err_sticky", 32'(bus.err), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
